// File: rtl/spi_flash_pkg.sv
// Shared constants and FSM state type for the SPI flash read master.
package spi_flash_pkg;

    localparam logic [7:0]  OP_READ         = 8'h03;
    localparam logic [7:0]  OP_QUAD_READ    = 8'h6B;
    localparam int unsigned ADDR_FIELD_BITS = 24;
    localparam int unsigned DUMMY_CYCLES    = 8;
    localparam int unsigned CMD_BITS        = 8;

    typedef enum logic [2:0] {
        StIdle,
        StCmd,
        StAddr,
        StDummy,
        StData,
        StDone
    } spi_state_e;

    // True while chip select is asserted and SCK is running.
    function automatic logic st_active(spi_state_e st);
        return (st == StCmd) || (st == StAddr) || (st == StDummy) || (st == StData);
    endfunction

endpackage

// File: rtl/spi_sck_gen.sv
// SPI mode-0 clock generator: DIV cycles low, DIV cycles high, with rise/fall strobes
// issued in the cycle before the registered sck edge; hold_i stalls the next rising edge.
module spi_sck_gen #(
    parameter int unsigned DIV = 1
) (
    input  logic clock_i,
    input  logic reset_i,
    input  logic en_i,
    input  logic hold_i,
    output logic sck_o,
    output logic rise_en_o,
    output logic fall_en_o
);

    localparam int unsigned     CntW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DIV - 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            sck_q, sck_d;

    always_comb begin
        cnt_d     = cnt_q;
        sck_d     = sck_q;
        rise_en_o = 1'b0;
        fall_en_o = 1'b0;
        if (!en_i) begin
            cnt_d = '0;
            sck_d = 1'b0;
        end else if (cnt_q == CntMax) begin
            if (!sck_q) begin
                // Low phase is simply extended while held; sck never glitches high.
                if (!hold_i) begin
                    rise_en_o = 1'b1;
                    sck_d     = 1'b1;
                    cnt_d     = '0;
                end
            end else begin
                fall_en_o = 1'b1;
                sck_d     = 1'b0;
                cnt_d     = '0;
            end
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_q <= '0;
            sck_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            sck_q <= sck_d;
        end
    end

    assign sck_o = sck_q;

endmodule

// File: rtl/spi_flash_read_master.sv
// SPI flash read initiator streaming bytes over valid/ready.
// Define SPI_FLASH_QUAD_EN for quad-output fast read (0x6B, 8 dummy cycles, 4-bit data).
module spi_flash_read_master
    import spi_flash_pkg::*;
#(
    parameter int unsigned ADDR_BITS = 24,
    parameter int unsigned LEN_BITS  = 8,
    parameter int unsigned DIV       = 1
) (
    input  logic                 clock_i,
    input  logic                 reset_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [ADDR_BITS-1:0] req_addr_i,
    input  logic [LEN_BITS-1:0]  req_len_i,
    output logic                 resp_valid_o,
    input  logic                 resp_ready_i,
    output logic [7:0]           resp_data_o,
    output logic                 sck_o,
    output logic                 cs_0_o,
    output logic [3:0]           dq_out_o,
    output logic [3:0]           dq_drive_o,
    input  logic [3:0]           dq_in_i
);

`ifdef SPI_FLASH_QUAD_EN
    localparam logic [7:0] Opcode = OP_QUAD_READ;
    localparam bit         QuadEn = 1'b1;
`else
    localparam logic [7:0] Opcode = OP_READ;
    localparam bit         QuadEn = 1'b0;
`endif

    localparam logic [4:0]       StepsPerByte = QuadEn ? 5'd2 : 5'd8;
    localparam int unsigned      DoneW        = $clog2(2 * DIV) + 1;
    localparam logic [DoneW-1:0] DoneMax      = DoneW'(2 * DIV - 1);

    spi_state_e           state_q, state_d;
    logic [31:0]          shift_q, shift_d;
    logic [4:0]           bit_cnt_q, bit_cnt_d;
    logic [LEN_BITS-1:0]  left_q, left_d;
    logic                 last_q, last_d;
    logic [7:0]           rx_q, rx_d;
    logic [7:0]           data_q, data_d;
    logic                 valid_q, valid_d;
    logic [DoneW-1:0]     done_cnt_q, done_cnt_d;
    logic                 live_q;

    logic       rise_en, fall_en, hold, accept;
    logic [7:0] rx_next;

    assign req_ready_o = live_q && (state_q == StIdle);
    assign accept      = req_valid_i && req_ready_o;
    assign rx_next     = QuadEn ? {rx_q[3:0], dq_in_i} : {rx_q[6:0], dq_in_i[1]};

    // Stall only before a byte's first rising edge, so a byte is never started
    // that could not be placed in the holding register.
    assign hold = (state_q == StData) && (bit_cnt_q == 5'd0) && valid_q && !resp_ready_i;

    spi_sck_gen #(
        .DIV (DIV)
    ) u_sck_gen (
        .clock_i   (clock_i),
        .reset_i   (reset_i),
        .en_i      (st_active(state_q)),
        .hold_i    (hold),
        .sck_o     (sck_o),
        .rise_en_o (rise_en),
        .fall_en_o (fall_en)
    );

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        left_d     = left_q;
        last_d     = last_q;
        rx_d       = rx_q;
        data_d     = data_q;
        valid_d    = valid_q;
        done_cnt_d = done_cnt_q;

        if (valid_q && resp_ready_i) begin
            valid_d = 1'b0;
        end

        case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d   = StCmd;
                    shift_d   = {Opcode, ADDR_FIELD_BITS'(req_addr_i)};
                    bit_cnt_d = '0;
                    left_d    = req_len_i;
                    last_d    = 1'b0;
                end
            end
            StCmd, StAddr, StDummy: begin
                if (rise_en) begin
                    bit_cnt_d = bit_cnt_q + 5'd1;
                end
                if (fall_en) begin
                    shift_d = {shift_q[30:0], 1'b0};
                    if (state_q == StCmd && bit_cnt_q == 5'(CMD_BITS)) begin
                        state_d   = StAddr;
                        bit_cnt_d = '0;
                    end else if (state_q == StAddr && bit_cnt_q == 5'(ADDR_FIELD_BITS)) begin
                        state_d   = QuadEn ? StDummy : StData;
                        bit_cnt_d = '0;
                    end else if (state_q == StDummy && bit_cnt_q == 5'(DUMMY_CYCLES)) begin
                        state_d   = StData;
                        bit_cnt_d = '0;
                    end
                end
            end
            StData: begin
                if (rise_en) begin
                    rx_d = rx_next;
                    if (bit_cnt_q == StepsPerByte - 5'd1) begin
                        bit_cnt_d = '0;
                        data_d    = rx_next;
                        valid_d   = 1'b1;
                        if (left_q == '0) begin
                            last_d = 1'b1;
                        end else begin
                            left_d = left_q - 1'b1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end
                if (fall_en && last_q) begin
                    state_d    = StDone;
                    done_cnt_d = '0;
                end
            end
            StDone: begin
                if (done_cnt_q == DoneMax) begin
                    state_d = StIdle;
                end else begin
                    done_cnt_d = done_cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= StIdle;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            left_q     <= '0;
            last_q     <= 1'b0;
            rx_q       <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            done_cnt_q <= '0;
            live_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            left_q     <= left_d;
            last_q     <= last_d;
            rx_q       <= rx_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            done_cnt_q <= done_cnt_d;
            live_q     <= 1'b1;
        end
    end

    assign cs_0_o       = !st_active(state_q);
    assign dq_drive_o   = (state_q == StCmd || state_q == StAddr) ? 4'b0001 : 4'b0000;
    assign dq_out_o     = {3'b000, shift_q[31] & dq_drive_o[0]};
    assign resp_valid_o = valid_q;
    assign resp_data_o  = data_q;

endmodule

// File: tb/tb_spi_flash_read_master.sv
// Self-checking bench for spi_flash_read_master with a behavioural SPI flash model.
module tb_spi_flash_read_master;

`ifdef SPI_FLASH_QUAD_EN
    localparam logic [7:0] ExpOp = 8'h6B;
    localparam int PreEdges = 40;
    localparam int StepsPerByte = 2;
    localparam int Edges0 = 42;
    localparam int Edges1 = 48;
    localparam int Edges2 = 44;
`else
    localparam logic [7:0] ExpOp = 8'h03;
    localparam int PreEdges = 32;
    localparam int StepsPerByte = 8;
    localparam int Edges0 = 40;
    localparam int Edges1 = 64;
    localparam int Edges2 = 48;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [23:0] req_addr = '0;
    logic [7:0]  req_len = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [7:0]  resp_data;
    logic        sck;
    logic        cs_0;
    logic [3:0]  dq_out;
    logic [3:0]  dq_drive;
    logic [3:0]  dq_in = 4'b0000;

    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    spi_flash_read_master #(
        .ADDR_BITS (24),
        .LEN_BITS  (8),
        .DIV       (1)
    ) dut (
        .clock_i      (clock),
        .reset_i      (reset),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_addr_i   (req_addr),
        .req_len_i    (req_len),
        .resp_valid_o (resp_valid),
        .resp_ready_i (resp_ready),
        .resp_data_o  (resp_data),
        .sck_o        (sck),
        .cs_0_o       (cs_0),
        .dq_out_o     (dq_out),
        .dq_drive_o   (dq_drive),
        .dq_in_i      (dq_in)
    );

    // Flash model: captures command/address on rising sck, drives data after falling sck.
    logic [7:0]  mbytes [4];
    logic [31:0] cmd_word = '0;
    int          edges = 0;
    int          last_edges = 0;
    int          drv_err = 0;

    always @(posedge sck or posedge cs_0) begin
        if (cs_0) begin
            last_edges = edges;
            edges = 0;
        end else begin
            if (edges < 32) begin
                cmd_word = {cmd_word[30:0], dq_out[0]};
                if (dq_drive !== 4'b0001) drv_err++;
            end else if (dq_drive !== 4'b0000) begin
                drv_err++;
            end
            edges++;
        end
    end

    always @(negedge sck) begin
        int idx;
        int pos;
        logic [7:0] b;
        if (!cs_0 && edges >= PreEdges) begin
            idx = edges - PreEdges;
            pos = idx % StepsPerByte;
            if (idx / StepsPerByte < 4) begin
                b = mbytes[idx / StepsPerByte];
`ifdef SPI_FLASH_QUAD_EN
                dq_in = (pos == 0) ? b[7:4] : b[3:0];
`else
                dq_in = {2'b00, b[7 - pos], 1'b0};
`endif
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_xfer(input logic [23:0] addr, input logic [7:0] len,
                            input logic [31:0] data, input int stall_in,
                            input int exp_edges, input string tag);
        logic [7:0] got [4];
        logic [7:0] first;
        int n, cycles, cs_hi, sck_hi, over, drv_base, stall;
        stall = stall_in;
        for (int i = 0; i < 4; i++) mbytes[i] = data[31 - 8 * i -: 8];
        cycles = 0;
        while (!req_ready && cycles < 200) begin
            @(posedge clock); #1;
            cycles++;
        end
        check({tag, " req_ready before request"}, req_ready, 1);
        drv_base = drv_err;
        req_valid = 1'b1;
        req_addr = addr;
        req_len = len;
        resp_ready = (stall == 0);
        @(posedge clock); #1;
        req_valid = 1'b0;
        check({tag, " cs_0 low at T+1"}, cs_0, 0);
        check({tag, " dq_drive at T+1"}, dq_drive, 4'b0001);
        check({tag, " req_ready low at T+1"}, req_ready, 0);
        n = 0;
        cycles = 0;
        while (n <= int'(len) && cycles < 3000) begin
            @(negedge clock);
            cycles++;
            if (resp_valid && resp_ready) begin
                got[n] = resp_data;
                n++;
            end else if (stall > 0 && resp_valid && !resp_ready) begin
                first = resp_data;
                sck_hi = 0;
                over = 0;
                for (int i = 0; i < stall; i++) begin
                    @(negedge clock);
                    if (sck) sck_hi++;
                    if (resp_data !== first || !resp_valid) over++;
                end
                check({tag, " sck frozen during stall"}, sck_hi, 0);
                check({tag, " holding register kept"}, over, 0);
                stall = 0;
                resp_ready = 1'b1;
                got[n] = resp_data;
                n++;
            end
        end
        check({tag, " byte count"}, n, int'(len) + 1);
        for (int i = 0; i <= int'(len) && i < n; i++) begin
            check($sformatf("%s byte %0d", tag, i), got[i], data[31 - 8 * i -: 8]);
        end
        cs_hi = 0;
        cycles = 0;
        do begin
            @(negedge clock);
            cycles++;
            if (cs_0 && !req_ready) cs_hi++;
        end while (!req_ready && cycles < 200);
        check({tag, " cs_0 high before ready"}, cs_hi, 2);
        check({tag, " rising edges"}, last_edges, exp_edges);
        check({tag, " opcode+address"}, cmd_word, {ExpOp, addr});
        check({tag, " dq_drive errors"}, drv_err - drv_base, 0);
    endtask

    typedef struct {
        logic [23:0] addr;
        logic [7:0]  len;
        logic [31:0] data;
        int          stall;
        int          edges;
    } vec_t;

    initial begin
        vec_t vecs [3];
        int accepts, rdy_seen, cycles, vld_seen;

        vecs[0] = '{addr: 24'h000123, len: 8'd0, data: 32'hA5000000, stall: 0, edges: Edges0};
        vecs[1] = '{addr: 24'h000010, len: 8'd3, data: 32'h11223344, stall: 50, edges: Edges1};
        vecs[2] = '{addr: 24'h000000, len: 8'd1, data: 32'h3C5A0000, stall: 0, edges: Edges2};

        // Reset state
        repeat (3) @(posedge clock);
        #1;
        check("reset cs_0", cs_0, 1);
        check("reset sck", sck, 0);
        check("reset dq_drive", dq_drive, 0);
        check("reset dq_out", dq_out, 0);
        check("reset resp_valid", resp_valid, 0);
        check("reset resp_data", resp_data, 0);
        check("reset req_ready", req_ready, 0);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock); #1;
        check("req_ready after release", req_ready, 1);

        // Reset while idle
        @(negedge clock);
        reset = 1'b1;
        #1;
        check("idle reset req_ready", req_ready, 0);
        check("idle reset cs_0", cs_0, 1);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock); #1;
        check("idle reset req_ready after", req_ready, 1);

        foreach (vecs[i]) begin
            run_xfer(vecs[i].addr, vecs[i].len, vecs[i].data, vecs[i].stall, vecs[i].edges,
                     $sformatf("vec%0d", i));
        end

        // req_valid held across a transfer; second request must use the new address
        mbytes[0] = 8'h96;
        req_addr = 24'h000123;
        req_len = 8'd0;
        resp_ready = 1'b1;
        req_valid = 1'b1;
        accepts = 0;
        rdy_seen = 0;
        cycles = 0;
        while (accepts < 2 && cycles < 500) begin
            @(negedge clock);
            cycles++;
            if (accepts == 1) begin
                req_addr = 24'h000456;
                if (req_ready) rdy_seen++;
            end
            if (req_valid && req_ready) begin
                accepts++;
                if (accepts == 2) begin
                    check("held first opcode+address", cmd_word, {ExpOp, 24'h000123});
                    check("held first rising edges", last_edges, Edges0);
                end
            end
        end
        @(posedge clock); #1;
        req_valid = 1'b0;
        check("held accept count", accepts, 2);
        check("held req_ready cycles between accepts", rdy_seen, 1);
        cycles = 0;
        while (!req_ready && cycles < 500) begin
            @(negedge clock);
            cycles++;
        end
        check("held second completes", req_ready, 1);
        check("held second opcode+address", cmd_word, {ExpOp, 24'h000456});

        // Reset pulsed during the address phase
        mbytes[0] = 8'hE7;
        @(negedge clock);
        req_addr = 24'hABCDEF;
        req_len = 8'd0;
        req_valid = 1'b1;
        @(posedge clock); #1;
        req_valid = 1'b0;
        cycles = 0;
        while (edges < 18 && cycles < 500) begin
            @(posedge clock); #1;
            cycles++;
        end
        check("reached address bit 10", edges, 18);
        #2;
        reset = 1'b1;
        #1;
        check("mid-addr reset cs_0", cs_0, 1);
        check("mid-addr reset sck", sck, 0);
        check("mid-addr reset dq_drive", dq_drive, 0);
        check("mid-addr reset resp_valid", resp_valid, 0);
        @(negedge clock);
        reset = 1'b0;
        vld_seen = 0;
        repeat (100) begin
            @(negedge clock);
            if (resp_valid) vld_seen++;
            if (!cs_0) vld_seen++;
        end
        check("no activity after abort", vld_seen, 0);
        run_xfer(vecs[0].addr, vecs[0].len, vecs[0].data, 0, vecs[0].edges, "post-reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
